// File: rtl/proc_param_if.sv
// proc_param_if: Run/Done handshake, instruction bus and status of proc_param.
// Zflag/Cflag exist only when PROC_FLAGS_EN is defined.
interface proc_param_if #(
    parameter int DATA_W = 9
);
    logic              run;
    logic [DATA_W-1:0] din;
    logic              done;
    logic              busy;
    logic [DATA_W-1:0] bus_wires;
`ifdef PROC_FLAGS_EN
    logic              zflag;
    logic              cflag;
    modport master (output run, din, input done, busy, bus_wires, zflag, cflag);
    modport slave  (input run, din, output done, busy, bus_wires, zflag, cflag);
`else
    modport master (output run, din, input done, busy, bus_wires);
    modport slave  (input run, din, output done, busy, bus_wires);
`endif
endinterface

// File: rtl/proc_param.sv
// proc_param: multicycle register-file processor, states T0..T3 sharing one bus.
// Define PROC_FLAGS_EN for Z/C flags and MVNZ on opcode 111 (otherwise 111 is a NOP).
module proc_param #(
    parameter int DATA_W = 9,
    parameter int NREGS  = 8,
    parameter int REG_B  = 3
) (
    input logic         clk,
    input logic         rst,
    proc_param_if.slave bus_if
);
    typedef enum logic [1:0] {T0, T1, T2, T3} state_t;
    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_X   = 3'b111;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] r_q [NREGS];
    logic [DATA_W-1:0] ir_q, ir_d, a_q, a_d, g_q, g_d, bus, b;
    logic [2:0]        op;
    logic [REG_B-1:0]  x, y;
    logic              rx_we;

    assign op = ir_q[DATA_W-1 -: 3];
    assign x  = ir_q[DATA_W-4 -: REG_B];
    assign y  = ir_q[DATA_W-4-REG_B -: REG_B];
    // The ALU operand is Ry directly; it equals the bus in T2 and avoids a comb loop through the bus.
    assign b  = r_q[y];

`ifdef PROC_FLAGS_EN
    logic              z_q, c_q, gc_q, gc_d;
    logic [DATA_W:0]   alu, srl;
    assign srl = {a_q, 1'b0} >> b[3:0];
    assign alu = (op == OP_ADD) ? {1'b0, a_q} + {1'b0, b} :
                 (op == OP_SUB) ? {1'b0, a_q} - {1'b0, b} :
                 (op == OP_AND) ? {1'b0, a_q & b} :
                 (op == OP_SLL) ? {1'b0, a_q} << b[3:0] :
                 (op == OP_SRL) ? {srl[0], srl[DATA_W:1]} : '0;
    assign bus_if.zflag = z_q;
    assign bus_if.cflag = c_q;
`else
    logic [DATA_W-1:0] alu;
    assign alu = (op == OP_ADD) ? a_q + b :
                 (op == OP_SUB) ? a_q - b :
                 (op == OP_AND) ? a_q & b :
                 (op == OP_SLL) ? a_q << b[3:0] :
                 (op == OP_SRL) ? a_q >> b[3:0] : '0;
`endif

    assign bus_if.busy      = (state_q != T0);
    assign bus_if.bus_wires = bus;

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        a_d         = a_q;
        g_d         = g_q;
        bus         = '0;
        rx_we       = 1'b0;
        bus_if.done = 1'b0;
`ifdef PROC_FLAGS_EN
        gc_d        = gc_q;
`endif
        case (state_q)
            T0: begin
                bus     = bus_if.din;
                ir_d    = bus_if.din;
                state_d = bus_if.run ? T1 : T0;
            end
            T1: begin
                if (op == OP_MV || op == OP_MVI || op == OP_X) begin
                    bus_if.done = 1'b1;
                    state_d     = T0;
                    if (op == OP_MVI) begin
                        bus   = bus_if.din;
                        rx_we = 1'b1;
                    end else if (op == OP_MV) begin
                        bus   = r_q[y];
                        rx_we = 1'b1;
                    end
`ifdef PROC_FLAGS_EN
                    else begin
                        bus   = r_q[y];
                        rx_we = !z_q;
                    end
`endif
                end else begin
                    bus     = r_q[x];
                    a_d     = r_q[x];
                    state_d = T2;
                end
            end
            T2: begin
                bus     = r_q[y];
                g_d     = alu[DATA_W-1:0];
`ifdef PROC_FLAGS_EN
                gc_d    = alu[DATA_W];
`endif
                state_d = T3;
            end
            default: begin
                bus         = g_q;
                rx_we       = 1'b1;
                bus_if.done = 1'b1;
                state_d     = T0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= T0;
            ir_q    <= '0;
            a_q     <= '0;
            g_q     <= '0;
            for (int i = 0; i < NREGS; i++) r_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            g_q     <= g_d;
            if (rx_we) r_q[x] <= bus;
        end
    end

`ifdef PROC_FLAGS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_q  <= 1'b0;
            c_q  <= 1'b0;
            gc_q <= 1'b0;
        end else begin
            gc_q <= gc_d;
            if (state_q == T3) begin
                z_q <= (g_q == '0);
                c_q <= gc_q;
            end
        end
    end
`endif
endmodule

// File: tb/tb_proc_param.sv
// tb_proc_param: scoreboard bench driving a 9-bit/8-reg and a 12-bit/16-reg proc_param side by side.
module tb_proc_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    proc_param_if #(.DATA_W(9))  if9 ();
    proc_param_if #(.DATA_W(12)) if12 ();

    proc_param #(.DATA_W(9), .NREGS(8), .REG_B(3)) dut9 (.clk(clk), .rst(rst), .bus_if(if9));
    proc_param #(.DATA_W(12), .NREGS(16), .REG_B(4)) dut12 (.clk(clk), .rst(rst), .bus_if(if12));

    logic        run_v [2];
    logic [11:0] din_v [2];
    logic        done_v [2];
    logic        busy_v [2];
    logic [11:0] bw_v [2];

    assign if9.run   = run_v[0];
    assign if9.din   = din_v[0][8:0];
    assign if12.run  = run_v[1];
    assign if12.din  = din_v[1];
    assign done_v[0] = if9.done;
    assign done_v[1] = if12.done;
    assign busy_v[0] = if9.busy;
    assign busy_v[1] = if12.busy;
    assign bw_v[0]   = {3'b000, if9.bus_wires};
    assign bw_v[1]   = if12.bus_wires;

    typedef struct {
        logic [11:0] val;
        int          lat;
        int          issue;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: every Done must match the oldest outstanding instruction of that core.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (done_v[k]) begin
                exp_t e;
                if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done core%0d: got Done=1, expected 0 (cycle %0d)", k, cyc);
                end else begin
                    e = (k == 0) ? q0.pop_front() : q1.pop_front();
                    chk($sformatf("result core%0d", k), bw_v[k], e.val);
                    chk($sformatf("latency core%0d", k), 12'(cyc - e.issue + 1), 12'(e.lat));
                    chk($sformatf("busy_at_done core%0d", k), {11'b0, busy_v[k]}, 12'h001);
                end
            end
        end
    end

    function automatic logic [11:0] enc(input int k, input logic [2:0] op, input logic [3:0] x, input logic [3:0] y);
        return (k == 0) ? {3'b000, op, x[2:0], y[2:0]} : {op, x, y, 1'b0};
    endfunction

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    // Issue one instruction; poke pulses Run during T2 of an ALU op, which must be ignored.
    task automatic exec(input int k, input logic [11:0] ins, input logic [11:0] imm,
                        input logic [11:0] val, input int lat, input bit poke = 1'b0);
        exp_t e;
        @(posedge clk);
        #1;
        run_v[k] = 1'b1;
        din_v[k] = ins;
        e.val = val;
        e.lat = lat;
        e.issue = cyc;
        if (k == 0) q0.push_back(e);
        else q1.push_back(e);
        @(posedge clk);
        #1;
        run_v[k] = 1'b0;
        din_v[k] = imm;
        if (poke) begin
            @(posedge clk);
            #1 run_v[k] = 1'b1;
            @(posedge clk);
            #1 run_v[k] = 1'b0;
        end
        for (int t = 0; t < 10 && qsize(k) != 0; t++) begin
            @(negedge clk);
            #1;
        end
        if (qsize(k) != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout core%0d: no Done within bound for instr %h", k, ins);
            if (k == 0) q0.delete();
            else q1.delete();
        end
    endtask

    task automatic idle_chk(input int k, input string nm);
        @(negedge clk);
        chk($sformatf("%s busy core%0d", nm, k), {11'b0, busy_v[k]}, 12'h000);
        chk($sformatf("%s done core%0d", nm, k), {11'b0, done_v[k]}, 12'h000);
    endtask

    task automatic flag_chk(input int k, input logic z, input logic c);
`ifdef PROC_FLAGS_EN
        @(negedge clk);
        chk($sformatf("zflag core%0d", k), {11'b0, (k == 0) ? if9.zflag : if12.zflag}, {11'b0, z});
        chk($sformatf("cflag core%0d", k), {11'b0, (k == 0) ? if9.cflag : if12.cflag}, {11'b0, c});
`else
        if (k < 0) $display("flags core%0d %b %b", k, z, c);
`endif
    endtask

    initial begin
        bit flg;
`ifdef PROC_FLAGS_EN
        flg = 1'b1;
`else
        flg = 1'b0;
`endif
        for (int k = 0; k < 2; k++) begin
            run_v[k] = 1'b0;
            din_v[k] = '0;
        end
        repeat (2) @(posedge clk);
        for (int k = 0; k < 2; k++) idle_chk(k, "reset");
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            exec(k, enc(k, 3'd1, 0, 0), 12'd5, 12'h005, 2);
            exec(k, enc(k, 3'd1, 1, 0), 12'd3, 12'h003, 2);
            exec(k, enc(k, 3'd2, 0, 1), 0, 12'h008, 4);
            idle_chk(k, "after_add");
            exec(k, enc(k, 3'd3, 1, 0), 0, k ? 12'hFFB : 12'h1FB, 4);
            flag_chk(k, 1'b0, 1'b1);
            exec(k, enc(k, 3'd1, 2, 0), 12'd3, 12'h003, 2);
            exec(k, enc(k, 3'd1, 3, 0), 12'd2, 12'h002, 2);
            exec(k, enc(k, 3'd5, 2, 3), 0, 12'h00C, 4);
            exec(k, enc(k, 3'd1, 3, 0), 12'd12, 12'h00C, 2);
            exec(k, enc(k, 3'd6, 2, 3), 0, 12'h000, 4);
            exec(k, enc(k, 3'd1, 4, 0), 12'h0F0, 12'h0F0, 2);
            exec(k, enc(k, 3'd1, 5, 0), 12'h1A5, 12'h1A5, 2);
            exec(k, enc(k, 3'd4, 4, 5), 0, 12'h0A0, 4);
            exec(k, enc(k, 3'd2, 1, 1), 0, k ? 12'hFF6 : 12'h1F6, 4);
            exec(k, enc(k, 3'd2, 0, 1), 0, k ? 12'hFFE : 12'h1FE, 4, 1'b1);
            idle_chk(k, "after_poke");
            idle_chk(k, "after_poke2");
            exec(k, enc(k, 3'd3, 4, 4), 0, 12'h000, 4);
            flag_chk(k, 1'b1, 1'b0);
            exec(k, enc(k, 3'd1, 6, 0), 12'h077, 12'h077, 2);
            exec(k, enc(k, 3'd1, 5, 0), 12'h011, 12'h011, 2);
            exec(k, enc(k, 3'd7, 5, 6), 0, flg ? 12'h077 : 12'h000, 2);
            exec(k, enc(k, 3'd0, 7, 5), 0, 12'h011, 2);
            exec(k, enc(k, 3'd2, 6, 6), 0, 12'h0EE, 4);
            exec(k, enc(k, 3'd7, 5, 6), 0, flg ? 12'h0EE : 12'h000, 2);
            exec(k, enc(k, 3'd0, 7, 5), 0, flg ? 12'h0EE : 12'h011, 2);
            // Abort an ADD in T2 with reset; no Done may follow and all registers read back 0.
            @(posedge clk);
            #1;
            run_v[k] = 1'b1;
            din_v[k] = enc(k, 3'd2, 0, 1);
            @(posedge clk);
            #1 run_v[k] = 1'b0;
            @(posedge clk);
            #2 rst = 1'b1;
            #4 rst = 1'b0;
            idle_chk(k, "abort");
            exec(k, enc(k, 3'd0, 0, 0), 0, 12'h000, 2);
            exec(k, enc(k, 3'd0, 6, 6), 0, 12'h000, 2);
            exec(k, enc(k, 3'd0, 1, 5), 0, 12'h000, 2);
            flag_chk(k, 1'b0, 1'b0);
        end
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
